// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  // Debug view of the arbiter state.
  typedef struct packed {
    owner_t     owner;
    logic       last_served_b;
    logic [1:0] idx;
    logic       slot_wrap;
  } dbg_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam int         DIGITS    = 4;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester-side bundle of the display arbiter: two clients' patterns plus the grant.
// req_x is a level request held while the client wants the display; gnt is one-hot {B, A}
// and is the only indication of ownership. Patterns are sampled live every cycle while granted.
interface seg_display_arbiter_if;
  logic        req_a;
  logic [27:0] seg_a;
  logic [3:0]  dp_a;
  logic [3:0]  en_a;
  logic        req_b;
  logic [27:0] seg_b;
  logic [3:0]  dp_b;
  logic [3:0]  en_b;
  logic [1:0]  gnt;

  modport master (
    output req_a, seg_a, dp_a, en_a,
    output req_b, seg_b, dp_b, en_b,
    input  gnt
  );

  modport slave (
    input  req_a, seg_a, dp_a, en_a,
    input  req_b, seg_b, dp_b, en_b,
    output gnt
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Digit slot timer: cnt runs 0..SCAN_DIV-1, idx steps 0..3 on each wrap; clr restarts both.
module seg_scan_timer
  import seg_arb_pkg::*;
#(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  output logic [1:0] idx,
  output logic       slot_wrap,
  output logic       in_blank_window
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;

  assign slot_wrap       = (cnt == CW'(SCAN_DIV - 1));
  assign in_blank_window = (cnt >= CW'(SCAN_DIV - BLANK_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (clr) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit 7-segment display with minimum hold time.
// Define SEG_ARB_GHOST_BLANK_EN to blank the last BLANK_CYCLES of every digit slot.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int SCAN_DIV     = 100_000,
  parameter int MIN_HOLD     = 50_000_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_arbiter_if.slave  bus,
  output logic [3:0]            an,
  output logic [6:0]            seg,
  output logic                  dp,
  output dbg_t                  dbg
);

`ifdef SEG_ARB_GHOST_BLANK_EN
  localparam bit GHOST_EN = 1'b1;
`else
  localparam bit GHOST_EN = 1'b0;
`endif

  localparam int            HW       = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD - 1);

  owner_t        owner_q, owner_d;
  logic          last_b_q;
  logic [HW-1:0] hold_q;
  logic          owner_chg;
  logic [1:0]    idx;
  logic          slot_wrap;
  logic          in_blank;
  logic [27:0]   seg_sel;
  logic [3:0]    dp_sel;
  logic [3:0]    en_sel;
  logic [4:0]    seg_base;
  logic          lit;

  assign owner_chg = (owner_d != owner_q);
  assign bus.gnt   = {owner_q == OWN_B, owner_q == OWN_A};
  assign dbg       = '{owner: owner_q, last_served_b: last_b_q, idx: idx, slot_wrap: slot_wrap};

  seg_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr             (owner_chg),
    .idx             (idx),
    .slot_wrap       (slot_wrap),
    .in_blank_window (in_blank)
  );

  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OWN_NONE: begin
        if (bus.req_a && bus.req_b) owner_d = last_b_q ? OWN_A : OWN_B;
        else if (bus.req_a)         owner_d = OWN_A;
        else if (bus.req_b)         owner_d = OWN_B;
      end
      OWN_A: begin
        if (!bus.req_a)                           owner_d = bus.req_b ? OWN_B : OWN_NONE;
        else if (bus.req_b && hold_q == HOLD_MAX) owner_d = OWN_B;
      end
      OWN_B: begin
        if (!bus.req_b)                           owner_d = bus.req_a ? OWN_A : OWN_NONE;
        else if (bus.req_a && hold_q == HOLD_MAX) owner_d = OWN_A;
      end
      default: owner_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      last_b_q <= 1'b1;
      hold_q   <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_chg) begin
        hold_q <= '0;
        if (owner_d != OWN_NONE) last_b_q <= (owner_d == OWN_B);
      end else if (owner_q != OWN_NONE && hold_q != HOLD_MAX) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  // The edge that hands over ownership always emits a blank frame.
  always_comb begin
    seg_sel  = (owner_q == OWN_B) ? bus.seg_b : bus.seg_a;
    dp_sel   = (owner_q == OWN_B) ? bus.dp_b  : bus.dp_a;
    en_sel   = (owner_q == OWN_B) ? bus.en_b  : bus.en_a;
    seg_base = {3'b000, idx} * 5'd7;
    lit      = (owner_q != OWN_NONE) && en_sel[idx] && !owner_chg && !(GHOST_EN && in_blank);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (lit) begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_sel[seg_base +: 7];
      dp  <= dp_sel[idx];
    end else begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule
